sram_access_ctrl: RTL
=====================

Name: sram_access_ctrl

Overview:
- Memory-access sequencer between the LC-3 datapath's MAR/MDR and the external asynchronous SRAM.
- The control FSM raises a request when MIO_EN is active; this block drives SRAM strobes with programmable wait states.
- Returns read data that feeds the datapath's MDR_In, with a one-cycle completion pulse, so control timing is independent of SRAM speed.

Parameters:
- WAIT_CYCLES, 2, cycles OE_N/WE_N held low per access; must be >=1, elaboration-time assertion if 0.
- SRAM_ADDR_W, 20, SRAM address width; CPU address is zero-extended into it.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Req  input  1  access request from control FSM; sampled only in IDLE.
- We  input  1  1 = write, 0 = read; latched with Req.
- Addr  input  16  MAR value; latched with Req.
- Wdata  input  16  MDR value; latched with Req.
- Ack  output  1  one-cycle completion pulse.
- Busy  output  1  high in every non-IDLE state.
- Rdata  output  16  last read result, to MDR_In.
- CE_N, OE_N, WE_N, UB_N, LB_N  output  1 each  SRAM strobes, active-low.
- ADDR  output  SRAM_ADDR_W  SRAM address.
- Data_to_SRAM  output  16  write data.
- Data_oe  output  1  tristate enable for Data_to_SRAM at the top level.
- Data_from_SRAM  input  16  SRAM read data.
- Switches  input  16  board switches, used only with IO_MAP_EN.
- Hex_out  output  16  hex-display register, used only with IO_MAP_EN.

Behaviour:
- Interface: one clock, Clk. Reset_n is asynchronous and active-low.
- Reset, asserted at any time including mid-access:
  - All strobes go to 1 immediately; Data_oe=0.
  - ADDR, Data_to_SRAM, Rdata, Hex_out = 0.
  - Ack=0, Busy=0; FSM returns to IDLE.
  - No Ack is produced for an aborted access.
- FSM IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
- IDLE:
  - Req=1 latches We, Addr and Wdata, then moves to SETUP.
  - Req is ignored in every other state.
- SETUP (1 cycle):
  - CE_N, UB_N, LB_N = 0; ADDR = zero-extended Addr.
  - On a write, Data_oe=1 and Data_to_SRAM=Wdata.
- ACCESS (WAIT_CYCLES cycles, down-counter):
  - Read: OE_N=0.
  - Write: WE_N=0; data is still driven.
  - On the final ACCESS cycle's edge, a read registers Data_from_SRAM into Rdata.
- HOLD (1 cycle):
  - OE_N and WE_N = 1; CE_N stays 0; write data is still driven (hold time).
  - Ack=1.
- Latency: Req seen high at edge T gives Ack high in the cycle after edge T+WAIT_CYCLES+2. WAIT_CYCLES=2 gives 4 cycles.
- Rdata:
  - Valid while Ack=1.
  - Held until the next read completes.
  - Unchanged by writes.
- Req held high through Ack: after HOLD the FSM returns to IDLE; a new access is accepted at the next edge. Back-to-back accesses therefore take WAIT_CYCLES+3 cycles each.
- OE_N and WE_N are never low in the same cycle. Data_oe is never high during a read.

Optional Feature:
- Macro: SRAM_ACCESS_CTRL_IO_MAP_EN.
- With the macro defined, latched Addr == 16'hFFFF is memory-mapped I/O:
  - CE_N, OE_N and WE_N all stay 1 for the whole access.
  - A read captures Switches into Rdata at the same point a SRAM read would.
  - A write loads Wdata into Hex_out in HOLD.
  - Latency is identical to a SRAM access.
- Without the macro:
  - 0xFFFF is an ordinary SRAM address.
  - Switches is ignored; Hex_out is held at 0.

Decomposition:
- Package lc3_mem_pkg:
  - state enum (IDLE, SETUP, ACCESS, HOLD).
  - IO_ADDR = 16'hFFFF.
  - default SRAM_ADDR_W.
- One sub-module, mem_wait_timer:
  - Loadable down-counter sized $clog2(WAIT_CYCLES+1).
  - Inputs: load, en. Output: done.
  - Instantiated once, for the ACCESS dwell.

Test Plan:
- Read: Reset_n pulse, then Req=1, We=0, Addr=16'h0012, SRAM model returns 16'hBEEF -> OE_N low exactly 2 cycles; Ack pulse in cycle 4 after request; Rdata=16'hBEEF; ADDR=20'h00012.
- Write: We=1, Addr=16'h0040, Wdata=16'h1234 -> WE_N low 2 cycles; Data_oe=1 from SETUP through HOLD; SRAM model holds 16'h1234 at 0x40; Rdata unchanged.
- Back-to-back with Req held high: write then read of 0x40 -> second Ack exactly 5 cycles after first; Rdata=16'h1234; Req ignored while Busy.
- Reset mid-op: Reset_n low during ACCESS of a write -> WE_N, CE_N, Data_oe inactive asynchronously; no Ack; next Req completes normally.
- WAIT_CYCLES=5 build: read -> OE_N low 5 cycles; Ack 7 cycles after Req.
- IO_MAP_EN: Switches=16'h00A5, read 0xFFFF -> Rdata=16'h00A5 with CE_N never low; write 16'h0F0F to 0xFFFF -> Hex_out=16'h0F0F. Without the macro, the same accesses hit SRAM.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared state encoding and constants for the LC-3 SRAM access path.
package lc3_mem_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [15:0] IO_ADDR             = 16'hFFFF;
  localparam int          DEFAULT_SRAM_ADDR_W = 20;
endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter that times the strobe dwell of one SRAM access.
// Latency: done rises LOAD_VAL-1 enabled cycles after the cycle following load.
// Backpressure: none; the owner decides when to load and enable.
module mem_wait_timer #(
  parameter int LOAD_VAL = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int CW = (LOAD_VAL < 1) ? 1 : $clog2(LOAD_VAL + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LOAD_VAL);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // done marks the last cycle of the dwell, so the owner can leave on this edge
  assign done = (cnt == CW'(1));
endmodule

// File: rtl/sram_access_ctrl.sv
// SRAM access sequencer for the LC-3 MAR/MDR path; I/O map at 0xFFFF via SRAM_ACCESS_CTRL_IO_MAP_EN.
// Latency: Req sampled at edge T gives Ack in the cycle after edge T+WAIT_CYCLES+2.
// Backpressure: Req is only sampled while idle; Busy flags an access in flight.
module sram_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_ADDR_W = DEFAULT_SRAM_ADDR_W
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Req,
  input  logic                   We,
  input  logic [15:0]            Addr,
  input  logic [15:0]            Wdata,
  output logic                   Ack,
  output logic                   Busy,
  output logic [15:0]            Rdata,
  output logic                   CE_N,
  output logic                   OE_N,
  output logic                   WE_N,
  output logic                   UB_N,
  output logic                   LB_N,
  output logic [SRAM_ADDR_W-1:0] ADDR,
  output logic [15:0]            Data_to_SRAM,
  output logic                   Data_oe,
  input  logic [15:0]            Data_from_SRAM,
  input  logic [15:0]            Switches,
  output logic [15:0]            Hex_out
);
  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("sram_access_ctrl: WAIT_CYCLES must be at least 1");
  end

  state_t      state;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        io_sel;
  logic [15:0] rd_src;
  logic        dwell_done;
  logic        timer_load;
  logic        timer_en;

  assign timer_load = (state == SETUP);
  assign timer_en   = (state == ACCESS);

  mem_wait_timer #(.LOAD_VAL(WAIT_CYCLES)) u_wait_timer (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .load    (timer_load),
    .en      (timer_en),
    .done    (dwell_done)
  );

`ifdef SRAM_ACCESS_CTRL_IO_MAP_EN
  assign io_sel = (addr_q == IO_ADDR);
  assign rd_src = io_sel ? Switches : Data_from_SRAM;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Hex_out <= '0;
    end else if ((state == HOLD) && we_q && io_sel) begin
      Hex_out <= wdata_q;
    end
  end
`else
  logic unused_switches;
  assign unused_switches = ^Switches;
  assign io_sel  = 1'b0;
  assign rd_src  = Data_from_SRAM;
  assign Hex_out = '0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (Req) begin
          we_q    <= We;
          addr_q  <= Addr;
          wdata_q <= Wdata;
          state   <= SETUP;
        end
        SETUP:   state <= ACCESS;
        ACCESS:  if (dwell_done) state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pins are a registered decode of the state, so each phase appears one cycle
  // after the FSM enters it; Rdata samples at the close of the last strobe cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      CE_N         <= 1'b1;
      OE_N         <= 1'b1;
      WE_N         <= 1'b1;
      UB_N         <= 1'b1;
      LB_N         <= 1'b1;
      Data_oe      <= 1'b0;
      ADDR         <= '0;
      Data_to_SRAM <= '0;
      Rdata        <= '0;
      Ack          <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      CE_N    <= (state == IDLE) || io_sel;
      OE_N    <= !((state == ACCESS) && !we_q && !io_sel);
      WE_N    <= !((state == ACCESS) && we_q && !io_sel);
      UB_N    <= (state == IDLE);
      LB_N    <= (state == IDLE);
      Data_oe <= (state != IDLE) && we_q;
      Ack     <= (state == HOLD);
      Busy    <= (state != IDLE);
      if (state != IDLE) ADDR <= SRAM_ADDR_W'(addr_q);
      if ((state != IDLE) && we_q) Data_to_SRAM <= wdata_q;
      if ((state == HOLD) && !we_q) Rdata <= rd_src;
    end
  end
endmodule
